csr_unit: RTL and testbench
===========================

# csr_unit

Control and status register unit inside `Riscv151`. It executes the Zicsr instructions (`csrrw`, `csrrs`, `csrrc`, `csrrwi`, `csrrsi`, `csrrci`) issued by the execute stage, and keeps the 64-bit `cycle` and `instret` counters. It owns the `tohost` register (0x51E) that drives the top-level `csr` port. Benches read that port as the pass/fail channel: `csr[0]` = done, `csr[31:1]` = failing test number.

## Interface
- `RESET_TOHOST`, default 32'h0: reset value of `tohost`.
- `clk` input 1: single clock, rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `csr_valid` input 1: execute stage holds a CSR instruction this cycle.
- `csr_stall` input 1: pipeline stalled; blocks the write and blocks counting of `retire`.
- `csr_funct3` input 3: instruction funct3 (3'b001..3'b011 register forms, 3'b101..3'b111 immediate forms).
- `csr_addr` input 12: CSR address, inst[31:20].
- `csr_rs1_data` input 32: forwarded rs1 value.
- `csr_uimm` input 5: rs1 field. Used as zero-extended immediate, or as the x0 test.
- `retire` input 1: one instruction retired this cycle.
- `csr_rdata` output 32: old CSR value for rd. Combinational.
- `csr_illegal` output 1: unknown address, or write to a read-only CSR. Combinational.
- `tohost` output 32: drives top-level `csr`. Registered; reset `RESET_TOHOST`.

## Operation
- Implemented CSRs:
  - 0x51E `tohost`, read/write.
  - 0xC00 `cycle`, read-only, low word.
  - 0xC80 `cycleh`, read-only, high word.
  - 0xC02 `instret`, read-only, low word.
  - 0xC82 `instreth`, read-only, high word.
- Source operand `src`:
  - `csr_rs1_data` when funct3[2]=0.
  - {27'b0, `csr_uimm`} when funct3[2]=1.
- New value, by funct3[1:0]:
  - 01 (RW): `src`.
  - 10 (RS): old | `src`.
  - 11 (RC): old & ~`src`.
  - 00: not a CSR op. `csr_illegal`=1, no effect.
- Write enable `we` = `csr_valid & ~csr_stall & ~csr_illegal & write_intent`.
  - `write_intent` = 1 for RW/RWI.
  - For RS/RC/RSI/RCI, `write_intent` = (`csr_uimm` != 0).
- Read-only CSRs:
  - `csr_illegal`=1 when `csr_valid` and `write_intent` target 0xC00/0xC80/0xC02/0xC82.
  - A pure read (e.g. `csrrs rd, cycle, x0`) is legal.
- `csr_rdata`:
  - Returns the pre-write value of the addressed CSR whenever `csr_valid`.
  - Returns 0 when not `csr_valid` or when `csr_illegal`.
- `cycle`: 64-bit counter, increments by 1 every clock after reset, including stalled cycles. Wraps 2^64-1 → 0.
- `instret`:
  - 64-bit, increments when `retire & ~csr_stall`. Wraps.
  - A CSR instruction reading `instret` sees the count excluding itself.
- Illegal accesses change no state. Trap handling belongs to the control unit.

## Timing
- Read path is combinational from current state; the control unit places it in the execute stage.
- `tohost` write takes effect at the rising edge ending the cycle in which `we`=1. It is visible on `tohost` the next cycle.
- Same-cycle write and read of `tohost` returns the old value on `csr_rdata`.
- Counters use a full 64-bit carry. A read of `cycleh` in cycle N returns the high word as of cycle N, with no skew against the low word.
- Reset (`rst`=1 at a rising edge):
  - `tohost` ← `RESET_TOHOST`; `cycle`, `instret` ← 0.
  - Reset dominates any write or increment in that cycle, including mid-stall.
- Stall held for multiple cycles: `tohost` and `instret` are frozen. `csr_rdata` stays valid and stable.

## Structure
- Package `riscv_csr_pkg` holds:
  - CSR address constants: `CSR_TOHOST`, `CSR_CYCLE`, `CSR_CYCLEH`, `CSR_INSTRET`, `CSR_INSTRETH`.
  - funct3 constants: `F3_CSRRW` .. `F3_CSRRCI`.
- One sub-module, `csr_counter64`: 64-bit counter with `clk`, `rst`, `inc` inputs and a `value[63:0]` output. Instantiated twice, once for `cycle` and once for `instret`.
- `csr_unit` holds decode, read mux, RW/RS/RC logic and the `tohost` register.

## Test plan
- Reset and tohost write:
  - Stimulus: assert `rst` 3 cycles, release; then `csrrwi tohost, 1` (funct3=101, uimm=1, addr 0x51E).
  - Required: `tohost`=0 throughout reset; `tohost`=32'h1 one cycle after the write; `csr_rdata`=0 during the write.
- Failure code, RS and RC:
  - Stimulus: `csrrw tohost` with rs1_data=32'h0000_000B; then `csrrs` with rs1_data=32'h10; then `csrrc` with rs1_data=32'h1.
  - Required: `tohost` goes 0x0B → 0x1B → 0x1A.
- Stalled write:
  - Stimulus: `csr_valid` and `csr_stall` both high 4 cycles with `csrrw tohost` of 32'hFFFF_FFFF, then stall drops.
  - Required: `tohost` unchanged during the stall; 32'hFFFF_FFFF the cycle after the stall releases.
- Read-only counters:
  - Stimulus: `csrrs cycle, x0` at 10 cycles after reset; then `csrrw cycle` with rs1_data=5.
  - Required: `csr_rdata`=10 with `csr_illegal`=0; then `csr_illegal`=1 and the counter is unaffected.
- instret under stall:
  - Stimulus: 20 `retire` pulses, 5 of them coincident with `csr_stall`.
  - Required: `instret` reads 15.
- Counter wrap:
  - Stimulus: force `cycle` to 64'h0000_0000_FFFF_FFFF, clock once.
  - Required: `cycle` low word reads 0, `cycleh` reads 1.

Source files
------------

// File: rtl/riscv_csr_pkg.sv
// Purpose: shared constants for the Riscv151 CSR unit: operand widths,
//          CSR address map and Zicsr funct3 encodings.
// Ports:   none (package).
package riscv_csr_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned CNT_W     = 64;
    localparam int unsigned CSR_AW    = 12;
    localparam int unsigned UIMM_W    = 5;
    localparam int unsigned F3_W      = 3;

    // CSR address map
    localparam logic [CSR_AW-1:0] CSR_TOHOST   = 12'h51E;
    localparam logic [CSR_AW-1:0] CSR_CYCLE    = 12'hC00;
    localparam logic [CSR_AW-1:0] CSR_CYCLEH   = 12'hC80;
    localparam logic [CSR_AW-1:0] CSR_INSTRET  = 12'hC02;
    localparam logic [CSR_AW-1:0] CSR_INSTRETH = 12'hC82;

    // Zicsr funct3 encodings; bit 2 selects the immediate form
    localparam logic [F3_W-1:0] F3_CSRRW  = 3'b001;
    localparam logic [F3_W-1:0] F3_CSRRS  = 3'b010;
    localparam logic [F3_W-1:0] F3_CSRRC  = 3'b011;
    localparam logic [F3_W-1:0] F3_CSRRWI = 3'b101;
    localparam logic [F3_W-1:0] F3_CSRRSI = 3'b110;
    localparam logic [F3_W-1:0] F3_CSRRCI = 3'b111;

    // funct3[1:0] operation classes
    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

endpackage

// File: rtl/csr_counter64.sv
// Purpose: free-running 64-bit counter with a full-width carry, used for
//          the cycle and instret CSRs. Wraps from all-ones to zero.
// Ports:   i_clk   - clock, rising edge
//          i_rst   - synchronous active-high reset (clears the count)
//          i_inc   - increment enable
//          o_value - current 64-bit count (registered)
module csr_counter64
    import riscv_csr_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_value
);

    logic [CNT_W-1:0] r_value;

    // Single 64-bit adder so high and low words never skew
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_value <= '0;
        end else if (i_inc) begin
            r_value <= r_value + CNT_W'(1);
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/csr_unit.sv
// Purpose: Zicsr execution for Riscv151. Decodes csrrw/csrrs/csrrc and their
//          immediate forms, serves the cycle/instret counters and owns the
//          tohost register that drives the top-level csr port.
// Ports:   i_clk          - clock, rising edge
//          i_rst          - synchronous active-high reset
//          i_csr_valid    - CSR instruction present in execute this cycle
//          i_csr_stall    - pipeline stall; blocks writes and retire counting
//          i_csr_funct3   - instruction funct3
//          i_csr_addr     - CSR address (inst[31:20])
//          i_csr_rs1_data - forwarded rs1 value
//          i_csr_uimm     - rs1 field: zero-extended immediate / x0 test
//          i_retire       - one instruction retired this cycle
//          o_csr_rdata    - pre-write CSR value for rd (combinational)
//          o_csr_illegal  - unknown CSR, bad funct3 or RO write (combinational)
//          o_tohost       - tohost register (registered)
module csr_unit
    import riscv_csr_pkg::*;
#(
    parameter logic [31:0] RESET_TOHOST = 32'h0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_csr_valid,
    input  logic              i_csr_stall,
    input  logic [F3_W-1:0]   i_csr_funct3,
    input  logic [CSR_AW-1:0] i_csr_addr,
    input  logic [XLEN-1:0]   i_csr_rs1_data,
    input  logic [UIMM_W-1:0] i_csr_uimm,
    input  logic              i_retire,
    output logic [XLEN-1:0]   o_csr_rdata,
    output logic              o_csr_illegal,
    output logic [XLEN-1:0]   o_tohost
);

    logic [XLEN-1:0]  r_tohost;
    logic [CNT_W-1:0] w_cycle;
    logic [CNT_W-1:0] w_instret;
    logic [XLEN-1:0]  w_src;
    logic [XLEN-1:0]  w_old;
    logic [XLEN-1:0]  w_new;
    csr_op_e          w_op;
    logic             w_known;
    logic             w_read_only;
    logic             w_write_intent;
    logic             w_illegal;
    logic             w_we;

    // Counters: cycle counts every clock, instret only unstalled retires
    csr_counter64 u_cycle_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (1'b1),
        .o_value (w_cycle)
    );

    csr_counter64 u_instret_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (i_retire & ~i_csr_stall),
        .o_value (w_instret)
    );

    // Operand select and operation class
    assign w_src = i_csr_funct3[2] ? {(XLEN-UIMM_W)'(0), i_csr_uimm} : i_csr_rs1_data;
    assign w_op  = csr_op_e'(i_csr_funct3[1:0]);

    // Set/clear with rs1=x0 (or uimm=0) is a pure read and must not count
    // as a write, so reading a read-only counter that way stays legal
    assign w_write_intent = (w_op == CSR_OP_RW) || (i_csr_uimm != UIMM_W'(0));

    // Address decode and pre-write value
    always_comb begin
        w_old       = '0;
        w_known     = 1'b1;
        w_read_only = 1'b1;
        case (i_csr_addr)
            CSR_TOHOST: begin
                w_old       = r_tohost;
                w_read_only = 1'b0;
            end
            CSR_CYCLE:    w_old = w_cycle[31:0];
            CSR_CYCLEH:   w_old = w_cycle[63:32];
            CSR_INSTRET:  w_old = w_instret[31:0];
            CSR_INSTRETH: w_old = w_instret[63:32];
            default: begin
                w_known     = 1'b0;
                w_read_only = 1'b0;
            end
        endcase
    end

    assign w_illegal = i_csr_valid &&
                       ((w_op == CSR_OP_NONE) || !w_known ||
                        (w_read_only && w_write_intent));

    // RW / RS / RC result
    always_comb begin
        w_new = w_old;
        case (w_op)
            CSR_OP_RW: w_new = w_src;
            CSR_OP_RS: w_new = w_old | w_src;
            CSR_OP_RC: w_new = w_old & ~w_src;
            default:   w_new = w_old;
        endcase
    end

    // tohost is the only writable CSR, so the decode folds into the enable
    assign w_we = i_csr_valid && !i_csr_stall && !w_illegal && w_write_intent &&
                  (i_csr_addr == CSR_TOHOST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tohost <= RESET_TOHOST;
        end else if (w_we) begin
            r_tohost <= w_new;
        end
    end

    assign o_csr_rdata   = (i_csr_valid && !w_illegal) ? w_old : '0;
    assign o_csr_illegal = w_illegal;
    assign o_tohost      = r_tohost;

endmodule

// File: tb/tb_csr_unit.sv
// Purpose: self-checking bench for csr_unit: table of single-cycle CSR
//          operations against tohost, then hand-written sequences for
//          reset, stall, read-only counters, instret gating and wrap.
module tb_csr_unit;
    import riscv_csr_pkg::*;

    logic        clk;
    logic        rst;
    logic        csr_valid;
    logic        csr_stall;
    logic [2:0]  csr_funct3;
    logic [11:0] csr_addr;
    logic [31:0] csr_rs1_data;
    logic [4:0]  csr_uimm;
    logic        retire;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic [31:0] tohost;

    int checks   = 0;
    int failures = 0;

    csr_unit dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_csr_valid    (csr_valid),
        .i_csr_stall    (csr_stall),
        .i_csr_funct3   (csr_funct3),
        .i_csr_addr     (csr_addr),
        .i_csr_rs1_data (csr_rs1_data),
        .i_csr_uimm     (csr_uimm),
        .i_retire       (retire),
        .o_csr_rdata    (csr_rdata),
        .o_csr_illegal  (csr_illegal),
        .o_tohost       (tohost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [2:0]  funct3;
        logic [11:0] addr;
        logic [31:0] rs1;
        logic [4:0]  uimm;
        logic [31:0] exp_rdata;
        logic        exp_illegal;
        logic [31:0] exp_tohost;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic [2:0] f3,
                         input logic [11:0] a, input logic [31:0] d, input logic [4:0] u);
        csr_valid    = v;
        csr_stall    = s;
        csr_funct3   = f3;
        csr_addr     = a;
        csr_rs1_data = d;
        csr_uimm     = u;
    endtask

    initial begin
        rst = 1'b1;
        retire = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 12'h000, 32'h0, 5'd0);

        //              valid f3         addr          rs1           uimm  rdata          ill   tohost
        vecs[0]  = '{1'b1, F3_CSRRWI, CSR_TOHOST, 32'h0000_0000, 5'd1, 32'h0000_0000, 1'b0, 32'h0000_0001};
        vecs[1]  = '{1'b1, F3_CSRRW,  CSR_TOHOST, 32'h0000_000B, 5'd1, 32'h0000_0001, 1'b0, 32'h0000_000B};
        vecs[2]  = '{1'b1, F3_CSRRS,  CSR_TOHOST, 32'h0000_0010, 5'd1, 32'h0000_000B, 1'b0, 32'h0000_001B};
        vecs[3]  = '{1'b1, F3_CSRRC,  CSR_TOHOST, 32'h0000_0001, 5'd1, 32'h0000_001B, 1'b0, 32'h0000_001A};
        vecs[4]  = '{1'b1, F3_CSRRS,  CSR_TOHOST, 32'hFFFF_FFFF, 5'd0, 32'h0000_001A, 1'b0, 32'h0000_001A};
        vecs[5]  = '{1'b1, F3_CSRRC,  CSR_TOHOST, 32'hFFFF_FFFF, 5'd0, 32'h0000_001A, 1'b0, 32'h0000_001A};
        vecs[6]  = '{1'b1, F3_CSRRSI, CSR_TOHOST, 32'hFFFF_FFFF, 5'd4, 32'h0000_001A, 1'b0, 32'h0000_001E};
        vecs[7]  = '{1'b1, F3_CSRRCI, CSR_TOHOST, 32'hFFFF_FFFF, 5'd2, 32'h0000_001E, 1'b0, 32'h0000_001C};
        vecs[8]  = '{1'b1, 3'b000,    CSR_TOHOST, 32'h0000_00FF, 5'd1, 32'h0000_0000, 1'b1, 32'h0000_001C};
        vecs[9]  = '{1'b1, 3'b100,    CSR_TOHOST, 32'h0000_00FF, 5'd1, 32'h0000_0000, 1'b1, 32'h0000_001C};
        vecs[10] = '{1'b1, F3_CSRRW,  12'h300,    32'h0000_0055, 5'd1, 32'h0000_0000, 1'b1, 32'h0000_001C};
        vecs[11] = '{1'b0, F3_CSRRW,  CSR_TOHOST, 32'h0000_0055, 5'd1, 32'h0000_0000, 1'b0, 32'h0000_001C};
        vecs[12] = '{1'b1, F3_CSRRW,  CSR_TOHOST, 32'hDEAD_BEEF, 5'd3, 32'h0000_001C, 1'b0, 32'hDEAD_BEEF};
        vecs[13] = '{1'b1, F3_CSRRW,  CSR_CYCLE,  32'h0000_0005, 5'd1, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF};
        vecs[14] = '{1'b1, F3_CSRRSI, CSR_INSTRETH, 32'h0,       5'd1, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF};
        vecs[15] = '{1'b1, F3_CSRRCI, CSR_CYCLEH, 32'h0,         5'd7, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF};

        // Reset held three cycles
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("tohost_in_reset", tohost, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Table: one CSR op per cycle, old value combinationally, tohost next cycle
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i].valid, 1'b0, vecs[i].funct3, vecs[i].addr, vecs[i].rs1, vecs[i].uimm);
            #1;
            check($sformatf("vec%0d_rdata", i), csr_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_illegal", i), 32'(csr_illegal), 32'(vecs[i].exp_illegal));
            @(posedge clk); #1;
            check($sformatf("vec%0d_tohost", i), tohost, vecs[i].exp_tohost);
        end

        // Stalled write: frozen for four cycles, lands once stall drops
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, F3_CSRRW, CSR_TOHOST, 32'hFFFF_FFFF, 5'd1);
            #1;
            check("stall_rdata", csr_rdata, 32'hDEAD_BEEF);
            @(posedge clk); #1;
            check("stall_tohost", tohost, 32'hDEAD_BEEF);
        end
        @(negedge clk);
        csr_stall = 1'b0;
        @(posedge clk); #1;
        check("stall_release_tohost", tohost, 32'hFFFF_FFFF);

        // Reset beats a same-cycle write
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b0, F3_CSRRW, CSR_TOHOST, 32'h0000_1234, 5'd1);
        @(posedge clk); #1;
        check("reset_beats_write", tohost, 32'h0);

        // Read-only cycle counter: pure read legal, write illegal
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, F3_CSRRS, CSR_CYCLE, 32'h0, 5'd0);
        #1;
        check("cycle_after_reset", csr_rdata, 32'd0);
        repeat (10) @(posedge clk);
        @(negedge clk); #1;
        check("cycle_10_rdata", csr_rdata, 32'd10);
        check("cycle_10_illegal", 32'(csr_illegal), 32'd0);
        csr_addr = CSR_CYCLEH;
        #1;
        check("cycleh_0", csr_rdata, 32'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, F3_CSRRW, CSR_CYCLE, 32'h5, 5'd1);
        #1;
        check("cycle_write_illegal", 32'(csr_illegal), 32'd1);
        check("cycle_write_rdata", csr_rdata, 32'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, F3_CSRRS, CSR_CYCLE, 32'h0, 5'd0);
        #1;
        check("cycle_unaffected", csr_rdata, 32'd12);

        // instret: 20 retires, 5 of them stalled
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(1'b0, (i % 4) == 0, 3'b000, 12'h000, 32'h0, 5'd0);
            retire = 1'b1;
        end
        @(negedge clk);
        retire = 1'b0;
        drive(1'b1, 1'b0, F3_CSRRS, CSR_INSTRET, 32'h0, 5'd0);
        #1;
        check("instret_15", csr_rdata, 32'd15);
        csr_addr = CSR_INSTRETH;
        #1;
        check("instreth_0", csr_rdata, 32'd0);
        csr_addr = CSR_INSTRET;
        retire = 1'b1;
        #1;
        check("instret_excludes_self", csr_rdata, 32'd15);
        @(negedge clk);
        retire = 1'b0;
        #1;
        check("instret_16", csr_rdata, 32'd16);

        // Low-word carry into the high word
        @(negedge clk);
        force dut.u_cycle_cnt.r_value = 64'h0000_0000_FFFF_FFFF;
        #1;
        release dut.u_cycle_cnt.r_value;
        drive(1'b1, 1'b0, F3_CSRRS, CSR_CYCLE, 32'h0, 5'd0);
        #1;
        check("wrap_preload", csr_rdata, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        check("wrap_cycle_lo", csr_rdata, 32'd0);
        csr_addr = CSR_CYCLEH;
        #1;
        check("wrap_cycleh", csr_rdata, 32'd1);

        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 12'h000, 32'h0, 5'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
